// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (see seg7_scan_ctrl.sv).
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex nibble to active-high segments, bit order gfedcba.
  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-slot cycle counter. Strobes mark the last blank cycle and the last
// cycle of the slot; clr forces the count back to zero on the next edge.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic blank_done,
  output logic slot_end
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Count up within a slot, restart on clear.
  always_comb begin
    cnt_d = clr ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign slot_end = (cnt_q == CW'(PRESCALE - 1));

  // With no blank phase the strobe is never needed.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign blank_done = (cnt_q == CW'(BLANK_CYCLES - 1));
    end else begin : g_noblank
      assign blank_done = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: FSM, digit ring, shadow/display
// registers and registered outputs. Shadow writes land on the display
// atomically at frame wrap (or continuously while the display is off).
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enabled,
  input  logic                      wr_en,
  input  logic [$clog2(DIGITS)-1:0] wr_idx,
  input  logic [3:0]                wr_data,
  input  logic                      wr_dp,
  output logic [DIGITS-1:0]         digit_sel,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int     IW       = $clog2(DIGITS);
  localparam state_e FIRST_ST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d, disp_q, disp_d;
  logic [DIGITS-1:0]       shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]       sel_q, sel_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d, fd_q, fd_d;
  logic                    blank_done, slot_end, tmr_clr, last_idx, wrap, commit;
  logic [DIGITS-1:0]       lz_mask;

  assign last_idx = (idx_q == IW'(DIGITS - 1));
  // The last slot of the frame ends; disabling suppresses the pulse.
  assign wrap     = enabled && (state_q == ST_SHOW) && slot_end && last_idx;
  assign tmr_clr  = !enabled || (state_q == ST_OFF) || slot_end;
  assign commit   = (state_q == ST_OFF) || wrap;

  seg7_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (tmr_clr),
    .blank_done (blank_done),
    .slot_end   (slot_end)
  );

  // Next state and digit index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enabled) begin
      state_d = ST_OFF;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = FIRST_ST;
          idx_d   = '0;
        end
        ST_BLANK: begin
          if (blank_done) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_end) begin
            state_d = FIRST_ST;
            idx_d   = last_idx ? '0 : idx_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Shadow writes; a write on the commit edge is folded into the commit.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (wr_en && (int'(wr_idx) < DIGITS)) begin
      shadow_d[wr_idx]    = wr_data;
      shadow_dp_d[wr_idx] = wr_dp;
    end
    disp_d    = commit ? shadow_d    : disp_q;
    disp_dp_d = commit ? shadow_dp_d : disp_dp_q;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Mark zero digits above the highest nonzero one; digit 0 always shows.
  always_comb begin
    logic above;
    lz_mask = '0;
    above   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      above      = above && (disp_q[i] == 4'h0);
      lz_mask[i] = above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Output decode from the current state/index, registered below.
  always_comb begin
    sel_d = '0;
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    fd_d  = wrap;
    if (state_q == ST_SHOW) begin
      sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
      seg_d = lz_mask[idx_q] ? SEG_OFF : hex2seg(disp_q[idx_q]);
      dp_d  = disp_dp_q[idx_q];
    end
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      sel_q       <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign digit_sel  = sel_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: DUT A (4 digits, 8-cycle slots, 2 blank) plus DUT B
// (3 digits, 4-cycle slots, no blank) for the no-blank and invalid-index cases.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0, wr_en_a = 1'b0, wr_dp_a = 1'b0;
  logic [1:0] wr_idx_a = '0;
  logic [3:0] wr_data_a = '0;
  logic [3:0] sel_a;
  logic [6:0] seg_a;
  logic       dp_a, fd_a;

  logic       en_b = 1'b0, wr_en_b = 1'b0, wr_dp_b = 1'b0;
  logic [1:0] wr_idx_b = '0;
  logic [3:0] wr_data_b = '0;
  logic [2:0] sel_b;
  logic [6:0] seg_b;
  logic       dp_b, fd_b;

  int tests = 0;
  int fails = 0;
  int k = 0;

  logic [6:0] hex_tbl [16];
  logic [3:0] cur [4];
  logic [3:0] nxt [4];
  logic       cdp [4];
  logic       ndp [4];
  logic [3:0] lzb = '0;

  seg7_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enabled(en_a), .wr_en(wr_en_a), .wr_idx(wr_idx_a),
    .wr_data(wr_data_a), .wr_dp(wr_dp_a), .digit_sel(sel_a), .seg(seg_a),
    .dp(dp_a), .frame_done(fd_a));

  seg7_scan_ctrl #(.DIGITS(3), .PRESCALE(4), .BLANK_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enabled(en_b), .wr_en(wr_en_b), .wr_idx(wr_idx_b),
    .wr_data(wr_data_b), .wr_dp(wr_dp_b), .digit_sel(sel_b), .seg(seg_b),
    .dp(dp_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int idx, input logic [3:0] d, input logic p);
    wr_en_a   = 1'b1;
    wr_idx_a  = 2'(idx);
    wr_data_a = d;
    wr_dp_a   = p;
    nxt[idx]  = d;
    ndp[idx]  = p;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel_a), 32'd0);
    chk({tag, "_seg"}, 32'(seg_a), 32'd0);
    chk({tag, "_dp"},  32'(dp_a),  32'd0);
    chk({tag, "_fd"},  32'(fd_a),  32'd0);
  endtask

  // k counts edges since the enabling edge; the output at edge k shows the
  // scan position k-1: 8-cycle slots, first 2 blank, commit at k%32==0.
  task automatic scan_a(input int n);
    int j, p, s;
    logic [31:0] es, eseg, edp;
    for (int i = 0; i < n; i++) begin
      tick();
      k++;
      j = k - 1; p = j % 8; s = (j / 8) % 4;
      es = 0; eseg = 0; edp = 0;
      if (p >= 2) begin
        es   = 32'(1 << s);
        eseg = lzb[s] ? 32'd0 : 32'(hex_tbl[cur[s]]);
        edp  = 32'(cdp[s]);
      end
      chk("a_sel", 32'(sel_a), es);
      chk("a_seg", 32'(seg_a), eseg);
      chk("a_dp",  32'(dp_a),  edp);
      chk("a_fd",  32'(fd_a),  32'((k % 32) == 0));
      if ((k % 32) == 0) begin
        cur = nxt;
        cdp = ndp;
      end
    end
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 4; i++) begin
      nxt[i] = '0; ndp[i] = 1'b0; cur[i] = '0; cdp[i] = 1'b0;
    end

    // Reset state
    #2;
    chk_a_zero("rst");
    chk("rst_b_sel", 32'(sel_b), 32'd0);
    chk("rst_b_fd",  32'(fd_b),  32'd0);
    #11 rst_n = 1'b1;
    tick();

    // DUT B: no blank phase; the out-of-range index write must change nothing
    wr_en_b = 1'b1; wr_dp_b = 1'b0;
    wr_idx_b = 2'd0; wr_data_b = 4'h1; tick();
    wr_idx_b = 2'd1; wr_data_b = 4'h2; tick();
    wr_idx_b = 2'd2; wr_data_b = 4'h3; tick();
    wr_idx_b = 2'd3; wr_data_b = 4'hF; wr_dp_b = 1'b1; tick();
    wr_en_b = 1'b0; wr_dp_b = 1'b0;
    en_b = 1'b1;
    tick();
    chk("b_sel_first", 32'(sel_b), 32'd0);
    for (int kb = 1; kb <= 14; kb++) begin
      int jb, sb;
      tick();
      jb = kb - 1; sb = (jb / 4) % 3;
      chk("b_sel", 32'(sel_b), 32'(1 << sb));
      chk("b_seg", 32'(seg_b), 32'(hex_tbl[sb + 1]));
      chk("b_dp",  32'(dp_b),  32'd0);
      chk("b_fd",  32'(fd_b),  32'((kb % 12) == 0));
    end
    en_b = 1'b0;

    // DUT A basic scan: write 1,2,3,4 while off (digit 2 with dp)
    wr_a(0, 4'h1, 1'b0); tick();
    wr_a(1, 4'h2, 1'b0); tick();
    wr_a(2, 4'h3, 1'b1); tick();
    wr_a(3, 4'h4, 1'b0); tick();
    wr_en_a = 1'b0;
    chk_a_zero("off");
    cur = nxt; cdp = ndp;
    en_a = 1'b1;
    tick();
    k = 0;
    chk_a_zero("en_edge");
    scan_a(40);

    // Atomic commit: writes during the digit-1 slot wait for the wrap
    wr_a(0, 4'h9, 1'b0); scan_a(1);
    wr_a(3, 4'hA, 1'b0); scan_a(1);
    wr_en_a = 1'b0;
    scan_a(21);

    // Write on the wrap edge is part of that commit
    wr_a(1, 4'hE, 1'b1); scan_a(1);
    wr_en_a = 1'b0;
    scan_a(19);

    // Disable during digit 2 SHOW; outputs clear, no frame pulse
    en_a = 1'b0;
    tick();
    tick();
    chk_a_zero("dis1");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a_zero("dis");
    end
    cur = nxt; cdp = ndp;

    // Re-enable restarts at digit 0 with a blank phase
    en_a = 1'b1;
    tick();
    k = 0;
    chk_a_zero("reen_edge");
    scan_a(12);

    // Display idx3..0 = 0,5,0,0: leading zero handling
    en_a = 1'b0;
    tick(); tick();
    wr_a(3, 4'h0, 1'b0); tick();
    wr_a(2, 4'h5, 1'b0); tick();
    wr_a(1, 4'h0, 1'b0); tick();
    wr_a(0, 4'h0, 1'b0); tick();
    wr_en_a = 1'b0;
    tick();
    cur = nxt; cdp = ndp;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lzb = 4'b1000;
`else
    lzb = 4'b0000;
`endif
    en_a = 1'b1;
    tick();
    k = 0;
    scan_a(36);

    // Reset mid-scan clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    chk_a_zero("rst_mid");
    #2;
    en_a  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a_zero("post_rst");
    end

    // Registers came back as zero
    for (int i = 0; i < 4; i++) begin
      nxt[i] = '0; ndp[i] = 1'b0;
    end
    cur = nxt; cdp = ndp;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lzb = 4'b1110;
`else
    lzb = 4'b0000;
`endif
    en_a = 1'b1;
    tick();
    k = 0;
    scan_a(16);
    en_a = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
